// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Brief    : Multi-cycle multiply/divide unit owning the HI/LO register pair.
//            Optional MADD/MSUB accumulate ops are enabled by MDU_MADD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] c_op_madd  = 3'd6;
    localparam logic [2:0] c_op_msub  = 3'd7;
`endif

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;

    logic w_accept;
    logic w_req_mul;
    logic w_req_div;
    logic w_req_madd;
    logic w_req_timed;

    // ------------------------------------------------------------------------
    // Request decode (uses the live op; only meaningful while idle)
    // ------------------------------------------------------------------------
    always_comb begin
        w_req_mul  = (op == c_op_mult) || (op == c_op_multu);
        w_req_div  = (op == c_op_div)  || (op == c_op_divu);
`ifdef MDU_MADD_EN
        w_req_madd = (op == c_op_madd) || (op == c_op_msub);
`else
        w_req_madd = 1'b0;
`endif
        w_req_timed = w_req_mul || w_req_div || w_req_madd;
        w_accept    = start && (r_state == S_IDLE);
    end

    // ------------------------------------------------------------------------
    // Shared magnitude datapath: one unsigned multiplier and one unsigned
    // divider serve both signed and unsigned ops via sign/magnitude fix-up.
    // ------------------------------------------------------------------------
    logic                 w_mul_signed;
    logic                 w_div_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_ma;
    logic [WIDTH-1:0]     w_mb;
    logic [WIDTH-1:0]     w_da;
    logic [WIDTH-1:0]     w_db;
    logic [WIDTH-1:0]     w_db_safe;
    logic                 w_b_zero;
    logic [2*WIDTH-1:0]   w_mul_mag;
    logic [2*WIDTH-1:0]   w_mul_res;
    logic [WIDTH-1:0]     w_quo_mag;
    logic [WIDTH-1:0]     w_rem_mag;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    always_comb begin
`ifdef MDU_MADD_EN
        w_mul_signed = (r_op == c_op_mult) || (r_op == c_op_madd) || (r_op == c_op_msub);
`else
        w_mul_signed = (r_op == c_op_mult);
`endif
        w_div_signed = (r_op == c_op_div);
        w_a_neg      = r_a[WIDTH-1];
        w_b_neg      = r_b[WIDTH-1];
        w_b_zero     = (r_b == '0);

        w_ma = (w_mul_signed && w_a_neg) ? -r_a : r_a;
        w_mb = (w_mul_signed && w_b_neg) ? -r_b : r_b;
        w_mul_mag = {{WIDTH{1'b0}}, w_ma} * {{WIDTH{1'b0}}, w_mb};
        w_mul_res = (w_mul_signed && (w_a_neg ^ w_b_neg)) ? -w_mul_mag : w_mul_mag;

        // Most-negative / -1 falls out naturally: magnitude 2^(W-1) negates to itself.
        w_da      = (w_div_signed && w_a_neg) ? -r_a : r_a;
        w_db      = (w_div_signed && w_b_neg) ? -r_b : r_b;
        w_db_safe = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_db;
        w_quo_mag = w_da / w_db_safe;
        w_rem_mag = w_da % w_db_safe;
        w_quo     = (w_div_signed && (w_a_neg ^ w_b_neg)) ? -w_quo_mag : w_quo_mag;
        w_rem     = (w_div_signed && w_a_neg) ? -w_rem_mag : w_rem_mag;
    end

    // ------------------------------------------------------------------------
    // Result selection for the write edge
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
`ifdef MDU_MADD_EN
    logic [2*WIDTH-1:0] w_acc;
    assign w_acc = {r_hi, r_lo};
`endif

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        case (r_op)
            c_op_mult, c_op_multu: begin
                {w_hi_nxt, w_lo_nxt} = w_mul_res;
            end
            c_op_div, c_op_divu: begin
                if (!w_b_zero) begin
                    w_hi_nxt = w_rem;
                    w_lo_nxt = w_quo;
                end
            end
`ifdef MDU_MADD_EN
            c_op_madd: begin
                {w_hi_nxt, w_lo_nxt} = w_acc + w_mul_res;
            end
            c_op_msub: begin
                {w_hi_nxt, w_lo_nxt} = w_acc - w_mul_res;
            end
`endif
            default: begin
                w_hi_nxt = r_hi;
                w_lo_nxt = r_lo;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM, operand latch and HI/LO registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_req_timed) begin
                            r_a     <= A;
                            r_b     <= B;
                            r_op    <= op;
                            r_cnt   <= w_req_div ? c_div_load : c_mult_load;
                            r_state <= S_RUN;
                        end else if (op == c_op_mthi) begin
                            r_hi <= A;
                        end else if (op == c_op_mtlo) begin
                            r_lo <= A;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt == c_cnt_one) begin
                        r_hi    <= w_hi_nxt;
                        r_lo    <= w_lo_nxt;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_unit
// Brief    : Scoreboard bench for mdu_unit against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_unit #(
        .WIDTH      (W),
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .HI   (HI),
        .LO   (LO)
    );

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural HI/LO pair.
    function automatic bit model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        logic [63:0] acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            3'd0: begin p = sa * sb; {m_hi, m_lo} = p; return 1'b1; end
            3'd1: begin p = ua * ub; {m_hi, m_lo} = p; return 1'b1; end
            3'd2: begin
                if (b != 0) begin
                    p = sa / sb; m_lo = p[31:0];
                    p = sa % sb; m_hi = p[31:0];
                end
                return 1'b1;
            end
            3'd3: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                return 1'b1;
            end
            3'd4: begin m_hi = a; return 1'b0; end
            3'd5: begin m_lo = a; return 1'b0; end
            default: begin
`ifdef MDU_MADD_EN
                acc = {m_hi, m_lo};
                p   = sa * sb;
                acc = (o == 3'd6) ? acc + p : acc - p;
                {m_hi, m_lo} = acc;
                return 1'b1;
`else
                acc = '0;
                p   = acc;
                return 1'b0;
`endif
            end
        endcase
    endfunction

    function automatic int cycles_for(input logic [2:0] o);
        return (o == 3'd2 || o == 3'd3) ? DC : MC;
    endfunction

    // Called at a falling edge; returns at a falling edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at = -1, input logic [2:0] inj_op = 3'd0,
                          input logic [31:0] inj_a = 32'd0);
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        bit          timed;
        bit          stable;
        int          cnt;
        pre_hi = m_hi;
        pre_lo = m_lo;
        timed  = model_op(o, a, b);
        if (timed) exp_q.push_back({m_hi, m_lo});
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        if (!timed) begin
            chk($sformatf("op%0d_immediate", o), {busy, done, HI, LO}, {2'b00, m_hi, m_lo});
        end else begin
            cnt    = 0;
            stable = 1'b1;
            while (busy === 1'b1 && cnt < 200) begin
                if (cnt == inj_at) begin
                    start = 1'b1; op = inj_op; A = inj_a; B = '0;
                end else begin
                    start = 1'b0;
                end
                if (HI !== pre_hi || LO !== pre_lo) stable = 1'b0;
                cnt++;
                @(negedge clk);
            end
            start = 1'b0;
            chk($sformatf("op%0d_busy_cycles", o), 66'(cnt), 66'(cycles_for(o)));
            chk($sformatf("op%0d_hilo_hold", o), 66'(stable), 66'd1);
            chk($sformatf("op%0d_done_pulse", o), 66'(done), 66'd1);
        end
    endtask

    // Monitor: every done pulse must retire exactly one scoreboard entry.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with HI=%h LO=%h, required no pending result", HI, LO);
            end else begin
                chk("scoreboard_hilo", {2'b00, HI, LO}, {2'b00, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0]  r_o;
    logic [31:0] r_a;
    logic [31:0] r_b;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, HI, LO}, 66'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg2x3", {2'b00, HI, LO}, {2'b00, 64'hFFFF_FFFF_FFFF_FFFA});
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("multu_x3", {2'b00, HI, LO}, {2'b00, 64'h0000_0002_FFFF_FFFA});
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg7_2", {2'b00, HI, LO}, {2'b00, 64'hFFFF_FFFF_FFFF_FFFD});

        run_op(3'd5, 32'h0000_1234, 32'd0);
        run_op(3'd4, 32'h0000_0000, 32'd0);
        run_op(3'd3, 32'd7, 32'd0);
        chk("divu_by_zero", {2'b00, HI, LO}, {2'b00, 64'h0000_0000_0000_1234});

        run_op(3'd2, 32'd100, 32'd7, 3, 3'd4, 32'd5);
        chk("div_ignored_mthi", {2'b00, HI, LO}, {2'b00, 64'h0000_0002_0000_000E});

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_overflow", {2'b00, HI, LO}, {2'b00, 64'h0000_0000_8000_0000});

        run_op(3'd4, 32'h0000_0000, 32'd0);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd0);
        run_op(3'd6, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        chk("madd_carry", {2'b00, HI, LO}, {2'b00, 64'h0000_0001_0000_0000});
        run_op(3'd7, 32'd1, 32'd1);
        chk("msub_borrow", {2'b00, HI, LO}, {2'b00, 64'h0000_0000_FFFF_FFFF});
`else
        chk("op6_noop", {2'b00, HI, LO}, {2'b00, 64'h0000_0000_FFFF_FFFF});
`endif

        for (int i = 0; i < 60; i++) begin
            r_o = 3'($urandom_range(0, 7));
            r_a = $urandom;
            r_b = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: r_b = 32'hFFFF_FFFF;
                2: r_a = 32'h8000_0000;
                3: r_b = 32'($urandom_range(1, 16));
                default: ;
            endcase
            run_op(r_o, r_a, r_b);
        end

        run_op(3'd4, 32'hA5A5_A5A5, 32'd0);
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("async_reset_midop", {busy, done, HI, LO}, 66'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (MC + 3) @(negedge clk);
        chk("post_reset_idle", {1'b0, busy, HI, LO}, 66'd0);

        run_op(3'd1, 32'd6, 32'd7);
        chk("after_reset_multu", {2'b00, HI, LO}, {2'b00, 64'h0000_0000_0000_002A});

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 66'(exp_q.size()), 66'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
